mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter RAM_ADDR_WIDTH, default 13, word-address width of the attached bram (8K x 32).
REQ-002 The module SHALL have input clk, 1 bit, the single system clock; all state updates on posedge clk.
REQ-003 The module SHALL have input rst, 1 bit, synchronous active-high reset.
REQ-004 The module SHALL have inputs p0_req and p1_req, 1 bit each: port request (p0 = instruction fetch, p1 = data).
REQ-005 The module SHALL have inputs pN_addr (32), pN_wdata (32), pN_we (1), pN_size (2; 00 byte, 01 half, 10 word) and pN_unsigned (1) for N = 0, 1.
REQ-006 The module SHALL have outputs p0_gnt and p1_gnt, 1 bit each: one-cycle pulse when the port's request is latched.
REQ-007 The module SHALL have outputs p0_done and p1_done, 1 bit each: one-cycle completion pulse.
REQ-008 The module SHALL have outputs rdata (32) and err (1), both valid only while a done is high.
REQ-009 The module SHALL have outputs bram_rd (1, active-low read strobe), bram_we (4, byte enables), bram_addr (RAM_ADDR_WIDTH) and bram_data (32); and input bram_out (32).

Function
REQ-010 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, and SHALL leave IDLE only on a request.
REQ-011 In IDLE with any req high, the module SHALL grant one port, pulse its gnt, latch addr/wdata/we/size/unsigned and the port ID, and go to ISSUE.
REQ-012 Arbitration SHALL be round-robin: when both requests are high, the grant goes to the port not granted last; the last-grant bit resets to 1, so p0 wins the first tie.
REQ-013 A lone request SHALL be granted regardless of the last-grant bit.
REQ-014 In ISSUE, the module SHALL drive bram_addr = latched addr[RAM_ADDR_WIDTH+1:2] for one cycle; reads drive bram_rd=0 and bram_we=0; writes drive bram_rd=1 and the computed byte enables; then go to WAIT.
REQ-015 Outside ISSUE, bram_rd SHALL be 1 and bram_we SHALL be 0.
REQ-016 Store byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-017 bram_data SHALL be the low byte replicated x4 for byte stores, the low half replicated x2 for half stores, and wdata for word stores.
REQ-018 In WAIT, the module SHALL capture and format bram_out into an rdata register, then go to RESP.
REQ-019 Load formatting SHALL select the byte at lane addr[1:0], or the half at lane addr[1]; the value is sign-extended unless unsigned=1, and words pass through unchanged.
REQ-020 In RESP, the module SHALL pulse done for the latched port only, present rdata and err, and return to IDLE.
REQ-021 Read latency SHALL be exactly 3 cycles from gnt to done; write latency SHALL be identical, with rdata=0 for writes.
REQ-022 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) SHALL set err=1, suppress the bram access (bram_rd=1, bram_we=0 in ISSUE), return rdata=0, and keep the same latency.
REQ-023 Out-of-range accesses (addr[31:RAM_ADDR_WIDTH+2] != 0) and size=11 SHALL be treated as in REQ-022.
REQ-024 A req still high during RESP SHALL NOT be granted until the following IDLE cycle; a req may drop after gnt without affecting the access.
REQ-025 p0_gnt and p1_gnt SHALL never be high together, and p0_done and p1_done SHALL never be high together.

Reset
REQ-026 With rst=1 at a clock edge, the module SHALL enter IDLE, set last-grant=1, and clear gnt, done, err and rdata to 0, bram_we to 0, bram_addr and bram_data to 0, and bram_rd to 1.
REQ-027 Reset during ISSUE, WAIT or RESP SHALL abort the access with no done pulse; a write aborted in ISSUE SHALL NOT commit (bram_we is 0 after the edge).

Verification
REQ-028 Scenario: p1 word write 0xDEADBEEF to addr 0x10, then p1 word read of 0x10 -> write shows bram_we=1111 and bram_addr=4; read shows done 3 cycles after gnt, rdata=0xDEADBEEF, err=0.
REQ-029 Scenario: mem word 0x80FF7F01, byte loads at addr+0..3, signed and unsigned -> 0x00000001, 0x0000007F, 0xFFFFFFFF/0x000000FF, 0xFFFFFF80/0x00000080; half load at +2 signed -> 0xFFFF80FF.
REQ-030 Scenario: byte store 0xAB at addr 0x13 -> bram_we=1000, bram_data=0xABABABAB; a following word read returns 0xAB in bits 31:24 with other bytes unchanged.
REQ-031 Scenario: p0_req and p1_req held high continuously after reset -> gnt order p0, p1, p0, p1; gnts are 4 cycles apart; never both done in one cycle.
REQ-032 Scenario: word read at 0x6 and at 0x00008000 (RAM_ADDR_WIDTH=13) -> err=1, rdata=0, bram_rd stays 1, latency 3 cycles.
REQ-033 Scenario: rst asserted in the ISSUE cycle of a write -> no done pulse, memory unchanged, FSM in IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter in front of a single-port 32x8K bram,
// with sub-word store lane steering, load formatting and misalign/range checking.
// Ports: clk, rst (sync, active-high); per port N=0,1: pN_req, pN_addr, pN_wdata,
//        pN_we, pN_size (00 byte, 01 half, 10 word), pN_unsigned in; pN_gnt, pN_done out.
//        rdata/err valid with done; bram_rd (active-low), bram_we (byte enables),
//        bram_addr, bram_data out; bram_out in (synchronous bram read data).
module mem_arbiter #(
    parameter int RAM_ADDR_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      p0_req,
    input  logic [31:0]               p0_addr,
    input  logic [31:0]               p0_wdata,
    input  logic                      p0_we,
    input  logic [1:0]                p0_size,
    input  logic                      p0_unsigned,
    input  logic                      p1_req,
    input  logic [31:0]               p1_addr,
    input  logic [31:0]               p1_wdata,
    input  logic                      p1_we,
    input  logic [1:0]                p1_size,
    input  logic                      p1_unsigned,
    output logic                      p0_gnt,
    output logic                      p1_gnt,
    output logic                      p0_done,
    output logic                      p1_done,
    output logic [31:0]               rdata,
    output logic                      err,
    output logic                      bram_rd,
    output logic [3:0]                bram_we,
    output logic [RAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]               bram_data,
    input  logic [31:0]               bram_out
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic        port;
    logic [31:0] addr, wdata, rdata_q, ld, wd;
    logic        we, uns, err_q, pick, bad;
    logic [1:0]  size;
    logic [3:0]  be;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // port holds the last-granted port; on a tie the other one wins
    assign pick = (p0_req && p1_req) ? ~port : p1_req;

    assign bad = size == 2'b11 || (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00) ||
                 (addr >> (RAM_ADDR_WIDTH + 2)) != 32'd0;

    assign be = size == 2'b00 ? 4'b0001 << addr[1:0] :
                size == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    assign wd = size == 2'b00 ? {4{wdata[7:0]}} :
                size == 2'b01 ? {2{wdata[15:0]}} : wdata;

    assign lane_b = bram_out[{addr[1:0], 3'b000} +: 8];
    assign lane_h = bram_out[{addr[1], 4'b0000} +: 16];
    assign ld = size == 2'b00 ? {{24{~uns & lane_b[7]}}, lane_b} :
                size == 2'b01 ? {{16{~uns & lane_h[15]}}, lane_h} : bram_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            port    <= 1'b1;
            addr    <= '0;
            wdata   <= '0;
            we      <= 1'b0;
            size    <= 2'b00;
            uns     <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (p0_req || p1_req)) begin
                port  <= pick;
                addr  <= pick ? p1_addr : p0_addr;
                wdata <= pick ? p1_wdata : p0_wdata;
                we    <= pick ? p1_we : p0_we;
                size  <= pick ? p1_size : p0_size;
                uns   <= pick ? p1_unsigned : p0_unsigned;
            end
            if (state == WAIT) begin
                rdata_q <= (bad || we) ? 32'd0 : ld;
                err_q   <= bad;
            end
        end
    end

    // Outputs are gated by rst so a reset edge never sees a grant, a done,
    // or a write strobe: an aborted write cannot commit into the bram.
    always_comb begin
        state_nxt = state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        rdata     = '0;
        err       = 1'b0;
        bram_rd   = 1'b1;
        bram_we   = 4'b0000;
        bram_addr = '0;
        bram_data = '0;
        if (!rst) begin
            case (state)
                IDLE: if (p0_req || p1_req) begin
                    state_nxt = ISSUE;
                    p0_gnt    = ~pick;
                    p1_gnt    = pick;
                end
                ISSUE: begin
                    state_nxt = WAIT;
                    bram_addr = addr[RAM_ADDR_WIDTH+1:2];
                    bram_data = wd;
                    bram_rd   = bad | we;
                    bram_we   = (!bad && we) ? be : 4'b0000;
                end
                WAIT: state_nxt = RESP;
                RESP: begin
                    state_nxt = IDLE;
                    p0_done   = ~port;
                    p1_done   = port;
                    rdata     = rdata_q;
                    err       = err_q;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a
// transaction-level reference model and a behavioural synchronous bram.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_i[2];
    logic [31:0] addr_i[2], wdata_i[2];
    logic        we_i[2], uns_i[2];
    logic [1:0]  size_i[2];
    logic [31:0] s_addr[2], s_wdata[2];
    logic        s_we[2], s_uns[2];
    logic [1:0]  s_size[2];

    logic        p0_gnt, p1_gnt, p0_done, p1_done, err, bram_rd;
    logic [31:0] rdata, bram_data, bram_out;
    logic [3:0]  bram_we;
    logic [12:0] bram_addr;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(req_i[0]), .p0_addr(addr_i[0]), .p0_wdata(wdata_i[0]), .p0_we(we_i[0]),
        .p0_size(size_i[0]), .p0_unsigned(uns_i[0]),
        .p1_req(req_i[1]), .p1_addr(addr_i[1]), .p1_wdata(wdata_i[1]), .p1_we(we_i[1]),
        .p1_size(size_i[1]), .p1_unsigned(uns_i[1]),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
        .rdata(rdata), .err(err), .bram_rd(bram_rd), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_data(bram_data), .bram_out(bram_out)
    );

    bit [31:0] mem[8192];
    bit [31:0] ref_mem[8192];

    always @(posedge clk) begin
        if (!bram_rd) bram_out <= mem[bram_addr];
        for (int k = 0; k < 4; k++)
            if (bram_we[k]) mem[bram_addr][8*k +: 8] <= bram_data[8*k +: 8];
    end

    int tests = 0, fails = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // reference model: one transaction in flight, t = cycles since its grant
    int        m_t = -1;
    int        m_port;
    bit        m_last = 1'b1;
    bit [31:0] m_a, m_wd, m_val, m_be, m_bd;
    bit        m_we, m_err, m_uns;
    bit [1:0]  m_sz;

    // observations used by directed scenarios
    int        g_last, d_cyc;
    int        g_cyc[$];
    int        g_port[$];
    bit [31:0] obs_rdata, obs_err, o_we, o_addr, o_data;
    bit        rd_seen, done_seen;

    task automatic model_grant(input int p);
        bit [31:0] w;
        int        sh;
        m_port = p;
        m_last = p[0];
        m_a = addr_i[p]; m_wd = wdata_i[p]; m_we = we_i[p]; m_sz = size_i[p]; m_uns = uns_i[p];
        m_err = (m_sz == 3) || (m_sz == 1 && m_a % 2 != 0) || (m_sz == 2 && m_a % 4 != 0) || m_a >= 32'h8000;
        w  = ref_mem[(m_a / 4) % 8192];
        sh = 8 * int'(m_a % 4);
        if (m_sz == 0) begin
            m_val = (w >> sh) & 32'hFF;
            if (!m_uns && m_val > 32'h7F) m_val = m_val | 32'hFFFFFF00;
        end else if (m_sz == 1) begin
            m_val = (w >> sh) & 32'hFFFF;
            if (!m_uns && m_val > 32'h7FFF) m_val = m_val | 32'hFFFF0000;
        end else m_val = w;
        m_be = m_sz == 0 ? (32'd1 << (m_a % 4)) : m_sz == 1 ? (32'd3 << (m_a % 4)) : 32'd15;
        m_bd = m_sz == 0 ? (m_wd & 32'hFF) * 32'h01010101 :
               m_sz == 1 ? (m_wd & 32'hFFFF) * 32'h00010001 : m_wd;
    endtask

    task automatic step(input bit r0, input bit r1, input bit do_rst);
        bit [31:0] e_g0 = 0, e_g1 = 0, e_d0 = 0, e_d1 = 0, e_rdata = 0, e_err = 0, e_rd = 1, e_we = 0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            addr_i[p] = s_addr[p]; wdata_i[p] = s_wdata[p]; we_i[p] = s_we[p];
            size_i[p] = s_size[p]; uns_i[p] = s_uns[p];
        end
        req_i[0] = r0; req_i[1] = r1; rst = do_rst;
        #1;
        cyc++;
        if (!do_rst) begin
            if (m_t < 0 && (r0 || r1)) begin
                model_grant((r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0));
                m_t = 0;
                if (m_port == 0) e_g0 = 1; else e_g1 = 1;
            end else if (m_t == 1 && !m_err) begin
                e_rd = m_we ? 1 : 0;
                e_we = m_we ? m_be : 0;
                chk("bram_addr", 32'(bram_addr), (m_a / 4) % 8192);
                if (m_we) chk("bram_data", bram_data, m_bd);
            end else if (m_t == 3) begin
                if (m_port == 0) e_d0 = 1; else e_d1 = 1;
                e_rdata = (m_err || m_we) ? 0 : m_val;
                e_err   = m_err;
            end
        end
        chk("p0_gnt", 32'(p0_gnt), e_g0);
        chk("p1_gnt", 32'(p1_gnt), e_g1);
        chk("p0_done", 32'(p0_done), e_d0);
        chk("p1_done", 32'(p1_done), e_d1);
        chk("rdata", rdata, e_rdata);
        chk("err", 32'(err), e_err);
        chk("bram_rd", 32'(bram_rd), e_rd);
        chk("bram_we", 32'(bram_we), e_we);
        if (p0_gnt || p1_gnt) begin
            g_last = cyc;
            g_cyc.push_back(cyc);
            g_port.push_back(p1_gnt ? 1 : 0);
        end
        if (p0_done || p1_done) begin
            obs_rdata = rdata; obs_err = 32'(err); d_cyc = cyc; done_seen = 1;
        end
        if (!bram_rd) rd_seen = 1;
        if (bram_we != 0) begin o_we = 32'(bram_we); o_addr = 32'(bram_addr); o_data = bram_data; end
        if (do_rst) begin
            m_t = -1;
            m_last = 1'b1;
        end else begin
            if (m_t == 1 && !m_err && m_we)
                for (int k = 0; k < (1 << m_sz); k++)
                    ref_mem[(m_a / 4) % 8192][8*(int'(m_a % 4) + k) +: 8] = m_wd[8*k +: 8];
            if (m_t >= 0) m_t = (m_t == 3) ? -1 : m_t + 1;
        end
    endtask

    task automatic setp(input int p, input bit [31:0] a, input bit [31:0] wd, input bit w,
                        input bit [1:0] sz, input bit u);
        s_addr[p] = a; s_wdata[p] = wd; s_we[p] = w; s_size[p] = sz; s_uns[p] = u;
    endtask

    task automatic txn(input int p);
        obs_rdata = 32'h5A5A5A5A; obs_err = 32'h5A; rd_seen = 0; o_we = 0; done_seen = 0;
        step(p == 0, p == 1, 0);
        repeat (3) step(0, 0, 0);
    endtask

    bit [31:0] exp_ld[8];
    int        diffs;

    initial begin
        for (int p = 0; p < 2; p++) begin
            req_i[p] = 0; addr_i[p] = 0; wdata_i[p] = 0; we_i[p] = 0; size_i[p] = 0; uns_i[p] = 0;
            setp(p, 0, 0, 0, 0, 0);
        end
        step(0, 0, 1);
        step(1, 1, 1);
        step(0, 0, 0);

        setp(1, 32'h10, 32'hDEADBEEF, 1, 2, 0);
        txn(1);
        chk("wr_we", o_we, 32'hF);
        chk("wr_addr", o_addr, 4);
        chk("wr_lat", d_cyc - g_last, 3);
        setp(1, 32'h10, 0, 0, 2, 0);
        txn(1);
        chk("rd_data", obs_rdata, 32'hDEADBEEF);
        chk("rd_err", obs_err, 0);
        chk("rd_lat", d_cyc - g_last, 3);

        setp(0, 32'h20, 32'h80FF7F01, 1, 2, 0);
        txn(0);
        exp_ld = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                   32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080};
        for (int i = 0; i < 8; i++) begin
            setp(0, 32'h20 + i % 4, 0, 0, 0, i / 4);
            txn(0);
            chk("ld_byte", obs_rdata, exp_ld[i]);
        end
        setp(0, 32'h22, 0, 0, 1, 0);
        txn(0);
        chk("ld_half", obs_rdata, 32'hFFFF80FF);

        setp(1, 32'h10, 32'h11223344, 1, 2, 0);
        txn(1);
        setp(1, 32'h13, 32'h000000AB, 1, 0, 0);
        txn(1);
        chk("sb_we", o_we, 32'h8);
        chk("sb_data", o_data, 32'hABABABAB);
        setp(1, 32'h10, 0, 0, 2, 0);
        txn(1);
        chk("sb_read", obs_rdata, 32'hAB223344);

        step(0, 0, 1);
        g_cyc.delete();
        g_port.delete();
        setp(0, 32'h20, 0, 0, 2, 0);
        setp(1, 32'h10, 0, 0, 2, 0);
        repeat (16) step(1, 1, 0);
        repeat (4) step(0, 0, 0);
        chk("rr_count", g_port.size(), 4);
        if (g_port.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                chk("rr_port", g_port[i], i % 2);
                if (i > 0) chk("rr_gap", g_cyc[i] - g_cyc[i-1], 4);
            end

        setp(0, 32'h6, 0, 0, 2, 0);
        txn(0);
        chk("mis_err", obs_err, 1);
        chk("mis_rdata", obs_rdata, 0);
        chk("mis_rd", rd_seen, 0);
        chk("mis_lat", d_cyc - g_last, 3);
        setp(0, 32'h8000, 0, 0, 2, 0);
        txn(0);
        chk("oor_err", obs_err, 1);
        chk("oor_rdata", obs_rdata, 0);
        chk("oor_rd", rd_seen, 0);
        chk("oor_lat", d_cyc - g_last, 3);

        setp(1, 32'h40, 32'h12345678, 1, 2, 0);
        txn(1);
        setp(1, 32'h40, 32'hCAFEF00D, 1, 2, 0);
        done_seen = 0; o_we = 0;
        step(0, 1, 0);
        step(0, 0, 1);
        repeat (4) step(0, 0, 0);
        chk("abort_done", done_seen, 0);
        chk("abort_we", o_we, 0);
        setp(1, 32'h40, 0, 0, 2, 0);
        txn(1);
        chk("abort_mem", obs_rdata, 32'h12345678);

        repeat (3000) begin
            for (int p = 0; p < 2; p++) begin
                int sel = $urandom_range(0, 15);
                s_addr[p]  = sel == 0 ? $urandom : sel == 1 ? 32'h8000 | $urandom_range(0, 3) : $urandom_range(0, 63);
                s_wdata[p] = $urandom;
                s_we[p]    = 1'($urandom_range(0, 1));
                s_size[p]  = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
                s_uns[p]   = 1'($urandom_range(0, 1));
            end
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
        end
        repeat (5) step(0, 0, 0);

        diffs = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] != ref_mem[i]) diffs++;
        chk("mem_image", diffs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
